// File: rtl/lcd_msg_arbiter_if.sv
// Write-port bus between the two burst requesters, the arbiter and the LCD message RAM.
interface lcd_msg_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 6
);
    logic              iREQ0,   iREQ1;
    logic [ADDR_W-1:0] iBASE0,  iBASE1;
    logic [LEN_W-1:0]  iLEN0,   iLEN1;
    logic [DATA_W-1:0] iDATA0,  iDATA1;
    logic              iVALID0, iVALID1;
    logic              oGNT0,   oGNT1;
    logic              oREADY0, oREADY1;
    logic              oDONE0,  oDONE1;
    logic              oWE;
    logic [ADDR_W-1:0] oWADDR;
    logic [DATA_W-1:0] oWDATA;

    modport master (
        output iREQ0, iREQ1, iBASE0, iBASE1, iLEN0, iLEN1,
               iDATA0, iDATA1, iVALID0, iVALID1,
        input  oGNT0, oGNT1, oREADY0, oREADY1, oDONE0, oDONE1,
               oWE, oWADDR, oWDATA
    );

    modport slave (
        input  iREQ0, iREQ1, iBASE0, iBASE1, iLEN0, iLEN1,
               iDATA0, iDATA1, iVALID0, iVALID1,
        output oGNT0, oGNT1, oREADY0, oREADY1, oDONE0, oDONE1,
               oWE, oWADDR, oWDATA
    );
endinterface

// File: rtl/lcd_msg_arbiter.sv
// Round-robin, burst-granular arbiter for the single write port of the LCD message RAM.
module lcd_msg_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 6
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    lcd_msg_arbiter_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, LOAD, XFER, DONE} state_t;

    state_t                    state, state_nxt;
    logic                      sel, sel_nxt;
    logic                      rr_ptr, rr_nxt;
    logic [ADDR_W-1:0]         addr;
    logic [CNT_W-1:0]          cnt, len_sat;
    logic [1:0]                req, vld;
    logic [1:0][ADDR_W-1:0]    base;
    logic [1:0][LEN_W-1:0]     len;
    logic [1:0][DATA_W-1:0]    data;
    logic                      own, xfer, beat;
    logic                      we;
    logic [ADDR_W-1:0]         waddr;
    logic [DATA_W-1:0]         wdata;

    assign req  = {bus.iREQ1,   bus.iREQ0};
    assign vld  = {bus.iVALID1, bus.iVALID0};
    assign base = {bus.iBASE1,  bus.iBASE0};
    assign len  = {bus.iLEN1,   bus.iLEN0};
    assign data = {bus.iDATA1,  bus.iDATA0};

    assign own  = (state != IDLE);
    assign xfer = (state == XFER);
    assign beat = xfer && vld[sel];

    assign bus.oGNT0   = own && !sel;
    assign bus.oGNT1   = own &&  sel;
    assign bus.oREADY0 = xfer && !sel;
    assign bus.oREADY1 = xfer &&  sel;
    assign bus.oDONE0  = (state == DONE) && !sel;
    assign bus.oDONE1  = (state == DONE) &&  sel;
    assign bus.oWE     = we;
    assign bus.oWADDR  = waddr;
    assign bus.oWDATA  = wdata;

    // A burst longer than the RAM would only overwrite itself, so clip it to one full pass.
    always_comb begin
        if (int'(len[sel]) > DEPTH) len_sat = CNT_W'(DEPTH);
        else                        len_sat = CNT_W'(len[sel]);
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        rr_nxt    = rr_ptr;
        case (state)
            IDLE: if (|req) begin
                sel_nxt   = req[1] && (!req[0] || rr_ptr);
                state_nxt = LOAD;
            end
            LOAD: begin
                if (!req[sel]) begin
                    state_nxt = IDLE;
                    rr_nxt    = !sel;
                end else if (len_sat == '0) state_nxt = DONE;
                else                        state_nxt = XFER;
            end
            XFER: begin
                // Dropping the request aborts; a beat taken in that same cycle is still written.
                if (!req[sel]) begin
                    state_nxt = IDLE;
                    rr_nxt    = !sel;
                end else if (beat && cnt == CNT_W'(1)) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
                rr_nxt    = !sel;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state  <= IDLE;
            sel    <= 1'b0;
            rr_ptr <= 1'b0;
            addr   <= '0;
            cnt    <= '0;
            we     <= 1'b0;
            waddr  <= '0;
            wdata  <= '0;
        end else begin
            state  <= state_nxt;
            sel    <= sel_nxt;
            rr_ptr <= rr_nxt;
            we     <= beat;
            if (beat) begin
                waddr <= addr;
                wdata <= data[sel];
            end
            if (state == LOAD) begin
                addr <= base[sel];
                cnt  <= len_sat;
            end else if (beat) begin
                addr <= addr + ADDR_W'(1);
                cnt  <= cnt - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// Directed bench for lcd_msg_arbiter: bursts, wrap, saturation, round-robin, stalls, abort, reset.
module tb_lcd_msg_arbiter;
    logic iCLK;
    logic iRST_N;
    int   tests = 0;
    int   fails = 0;

    lcd_msg_arbiter_if #(.ADDR_W(5), .DATA_W(8), .LEN_W(6)) bus ();

    lcd_msg_arbiter #(.ADDR_W(5), .DATA_W(8), .LEN_W(6)) dut (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .bus    (bus)
    );

    initial iCLK = 1'b0;
    always #10 iCLK = ~iCLK;

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic v);
        if (r == 0) bus.iREQ0 = v; else bus.iREQ1 = v;
    endtask

    // Valid held high; beat j is expected at address (base+j)%32 with data 0x40+j.
    task automatic burst(input int r, input int b, input int l, input int exp_n,
                         input int exp_last, input string tag);
        int n = 0, presented = 0, last = -1;
        bit got_done = 0;
        if (r == 0) begin
            bus.iBASE0 = 5'(b); bus.iLEN0 = 6'(l); bus.iVALID0 = 1'b1; bus.iDATA0 = 8'h40;
        end else begin
            bus.iBASE1 = 5'(b); bus.iLEN1 = 6'(l); bus.iVALID1 = 1'b1; bus.iDATA1 = 8'h40;
        end
        set_req(r, 1'b1);
        for (int c = 0; c < 80 && !got_done; c++) begin
            step();
            if (bus.oWE) begin
                chk({tag, "_addr"}, bus.oWADDR, 32'((b + n) % 32));
                chk({tag, "_data"}, bus.oWDATA, 32'(8'h40 + n));
                last = int'(bus.oWADDR);
                n++;
            end
            chk({tag, "_other_gnt"}, (r == 0) ? bus.oGNT1 : bus.oGNT0, 0);
            if ((r == 0) ? bus.oDONE0 : bus.oDONE1) got_done = 1;
            if ((r == 0) ? bus.oREADY0 : bus.oREADY1) begin
                if (r == 0) bus.iDATA0 = 8'(8'h40 + presented);
                else        bus.iDATA1 = 8'(8'h40 + presented);
                presented++;
            end
        end
        chk({tag, "_done_seen"}, 32'(got_done), 1);
        chk({tag, "_nwrites"}, n, exp_n);
        chk({tag, "_last_addr"}, last, exp_last);
        set_req(r, 1'b0);
        bus.iVALID0 = 1'b0;
        bus.iVALID1 = 1'b0;
        step();
        chk({tag, "_gnt_off"}, {bus.oGNT0, bus.oGNT1}, 0);
    endtask

    initial begin
        logic [5:0] pat;
        int         k;
        int         ndone;
        int         order[4];

        iRST_N = 1'b0;
        bus.iREQ0 = 0; bus.iREQ1 = 0; bus.iVALID0 = 0; bus.iVALID1 = 0;
        bus.iBASE0 = 0; bus.iBASE1 = 0; bus.iLEN0 = 0; bus.iLEN1 = 0;
        bus.iDATA0 = 0; bus.iDATA1 = 0;
        step(); step();

        // Reset state
        chk("rst_gnt",   {bus.oGNT0, bus.oGNT1}, 0);
        chk("rst_ready", {bus.oREADY0, bus.oREADY1}, 0);
        chk("rst_done",  {bus.oDONE0, bus.oDONE1}, 0);
        chk("rst_we",    bus.oWE, 0);
        chk("rst_waddr", bus.oWADDR, 0);
        chk("rst_wdata", bus.oWDATA, 0);
        iRST_N = 1'b1;

        // Single burst base 3 len 4, exact cycle timing
        bus.iREQ0 = 1; bus.iBASE0 = 3; bus.iLEN0 = 4; bus.iVALID0 = 1; bus.iDATA0 = 8'h41;
        step();
        chk("sb_load_gnt", bus.oGNT0, 1);
        chk("sb_load_rdy", bus.oREADY0, 0);
        step();
        chk("sb_xfer_rdy", bus.oREADY0, 1);
        chk("sb_xfer_we",  bus.oWE, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("sb_we",    bus.oWE, 1);
            chk("sb_addr",  bus.oWADDR, 32'(3 + i));
            chk("sb_data",  bus.oWDATA, 32'(8'h41 + i));
            chk("sb_gnt1",  bus.oGNT1, 0);
            chk("sb_done",  bus.oDONE0, (i == 3) ? 1 : 0);
            chk("sb_rdy",   bus.oREADY0, (i == 3) ? 0 : 1);
            bus.iDATA0 = 8'(8'h42 + i);
        end
        bus.iREQ0 = 0; bus.iVALID0 = 0;
        step();
        chk("sb_idle_gnt",  bus.oGNT0, 0);
        chk("sb_idle_done", bus.oDONE0, 0);
        chk("sb_idle_we",   bus.oWE, 0);

        // Wrap and saturate
        burst(0, 30, 3, 3, 0, "wrap");
        burst(1, 7, 40, 32, 6, "sat");

        // Tie and round-robin from reset
        iRST_N = 1'b0; step(); iRST_N = 1'b1;
        bus.iBASE0 = 0; bus.iLEN0 = 2; bus.iBASE1 = 16; bus.iLEN1 = 2;
        bus.iVALID0 = 1; bus.iVALID1 = 1; bus.iREQ0 = 1; bus.iREQ1 = 1;
        ndone = 0;
        for (int c = 0; c < 40 && ndone < 4; c++) begin
            step();
            chk("rr_excl",  bus.oGNT0 & bus.oGNT1, 0);
            chk("rr_rdy0",  bus.oREADY0 & !bus.oGNT0, 0);
            chk("rr_rdy1",  bus.oREADY1 & !bus.oGNT1, 0);
            if (bus.oDONE0 | bus.oDONE1) begin
                order[ndone] = int'(bus.oDONE1);
                ndone++;
            end
        end
        bus.iREQ0 = 0; bus.iREQ1 = 0; bus.iVALID0 = 0; bus.iVALID1 = 0;
        chk("rr_ndone", ndone, 4);
        for (int i = 0; i < 4; i++) chk("rr_order", order[i], i % 2);
        step(); step();

        // Stalls: len 3, valid pattern 1,0,0,1,0,1
        pat = 6'b101001;
        k = 0;
        bus.iREQ0 = 1; bus.iBASE0 = 10; bus.iLEN0 = 3; bus.iVALID0 = 0;
        step();
        chk("st_load_gnt", bus.oGNT0, 1);
        step();
        chk("st_xfer_rdy", bus.oREADY0, 1);
        for (int i = 0; i < 6; i++) begin
            bus.iVALID0 = pat[i];
            bus.iDATA0  = 8'(8'h60 + i);
            step();
            chk("st_we", bus.oWE, pat[i]);
            if (pat[i]) begin
                chk("st_addr", bus.oWADDR, 32'(10 + k));
                chk("st_data", bus.oWDATA, 32'(8'h60 + i));
                k++;
            end
            chk("st_done", bus.oDONE0, (i == 5) ? 1 : 0);
        end
        chk("st_nwrites", k, 3);
        bus.iREQ0 = 0; bus.iVALID0 = 0;
        step();
        chk("st_idle", {bus.oGNT0, bus.oWE}, 0);

        // Zero length
        bus.iREQ1 = 1; bus.iBASE1 = 4; bus.iLEN1 = 0; bus.iVALID1 = 1;
        step();
        chk("z_load_gnt", bus.oGNT1, 1);
        chk("z_load_we",  bus.oWE, 0);
        chk("z_load_rdy", bus.oREADY1, 0);
        step();
        chk("z_done",    bus.oDONE1, 1);
        chk("z_done_we", bus.oWE, 0);
        bus.iREQ1 = 0; bus.iVALID1 = 0;
        step();
        chk("z_idle", {bus.oDONE1, bus.oGNT1, bus.oWE}, 0);

        // Abort requester 1 after 2 of 5 beats, requester 0 waiting
        bus.iREQ1 = 1; bus.iBASE1 = 20; bus.iLEN1 = 5; bus.iVALID1 = 1; bus.iDATA1 = 8'h70;
        step();
        chk("ab_load_gnt", bus.oGNT1, 1);
        bus.iREQ0 = 1; bus.iBASE0 = 0; bus.iLEN0 = 1; bus.iVALID0 = 1; bus.iDATA0 = 8'h55;
        step();
        chk("ab_rdy1", bus.oREADY1, 1);
        chk("ab_rdy0", bus.oREADY0, 0);
        step();
        chk("ab_w1",   {bus.oWE, 3'b0, bus.oWADDR, bus.oWDATA}, {1'b1, 3'b0, 5'd20, 8'h70});
        bus.iDATA1 = 8'h71;
        step();
        chk("ab_w2",   {bus.oWE, 3'b0, bus.oWADDR, bus.oWDATA}, {1'b1, 3'b0, 5'd21, 8'h71});
        bus.iREQ1 = 0; bus.iVALID1 = 0;
        step();
        chk("ab_we",    bus.oWE, 0);
        chk("ab_done1", bus.oDONE1, 0);
        chk("ab_gnt1",  bus.oGNT1, 0);
        step();
        chk("ab_next_gnt0", bus.oGNT0, 1);
        step();
        chk("ab_next_rdy0", bus.oREADY0, 1);
        step();
        chk("ab_next_w", {bus.oWE, 3'b0, bus.oWADDR, bus.oWDATA}, {1'b1, 3'b0, 5'd0, 8'h55});
        chk("ab_next_done", bus.oDONE0, 1);
        bus.iREQ0 = 0; bus.iVALID0 = 0;
        step();

        // Reset mid-burst, then requester 0 favoured on a fresh tie
        bus.iREQ0 = 1; bus.iBASE0 = 5; bus.iLEN0 = 10; bus.iVALID0 = 1; bus.iDATA0 = 8'h33;
        step(); step(); step();
        chk("mr_we_before", bus.oWE, 1);
        iRST_N = 1'b0;
        step();
        chk("mr_gnt",   {bus.oGNT0, bus.oGNT1}, 0);
        chk("mr_ready", {bus.oREADY0, bus.oREADY1}, 0);
        chk("mr_done",  {bus.oDONE0, bus.oDONE1}, 0);
        chk("mr_wport", {bus.oWE, 3'b0, bus.oWADDR, bus.oWDATA}, 0);
        iRST_N = 1'b1;
        bus.iREQ1 = 1; bus.iBASE1 = 1; bus.iLEN1 = 1; bus.iVALID1 = 1;
        step();
        chk("mr_fresh_gnt0", bus.oGNT0, 1);
        chk("mr_fresh_gnt1", bus.oGNT1, 0);
        bus.iREQ0 = 0; bus.iREQ1 = 0; bus.iVALID0 = 0; bus.iVALID1 = 0;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/lcd_msg_arbiter.md
Name: lcd_msg_arbiter

Overview:
- Shares the single write port of the 32-entry LCD message RAM between two burst requesters: the front-panel editor (requester 0) and an autonomous status writer (requester 1).
- The LCD display controller keeps reading the RAM independently.
- Each granted requester streams a burst of characters to consecutive, wrapping addresses.
- Arbitration is round-robin at burst granularity; a granted burst is never preempted by the other requester.

Parameters:
- ADDR_W, 5, message RAM address width (DEPTH = 2**ADDR_W = 32 characters).
- DATA_W, 8, character width (ASCII).
- LEN_W, 6, burst length field width (values 0..63).

Ports:
- iCLK  in  1  system clock (50 MHz).
- iRST_N  in  1  reset, active-low.
- iREQ0 / iREQ1  in  1  burst request, level; held high until oDONEx or abort.
- iBASE0 / iBASE1  in  ADDR_W  first RAM address of burst.
- iLEN0 / iLEN1  in  LEN_W  number of characters.
- iDATA0 / iDATA1  in  DATA_W  beat data.
- iVALID0 / iVALID1  in  1  beat data valid.
- oGNT0 / oGNT1  out  1  requester owns the write port.
- oREADY0 / oREADY1  out  1  arbiter accepts a beat this cycle.
- oDONE0 / oDONE1  out  1  one-cycle pulse: burst complete.
- oWE  out  1  RAM write enable.
- oWADDR  out  ADDR_W  RAM write address.
- oWDATA  out  DATA_W  RAM write data.

Behaviour:
- Clock and reset: one clock, iCLK. Reset iRST_N is synchronous and active-low.
- Reset values: all outputs 0. FSM = IDLE. Round-robin pointer favours requester 0.
- FSM states: IDLE, LOAD, XFER, DONE.
- IDLE:
  - If either iREQ is high, select the winner, then go to LOAD.
  - Both high: the requester not granted most recently wins.
  - After reset, requester 0 wins a tie.
- LOAD (1 cycle):
  - Latch iBASEx into the address counter.
  - Latch the length, saturated to DEPTH (length > 32 becomes 32).
  - Assert oGNTx.
  - If the latched length is 0, go to DONE; otherwise go to XFER.
- XFER:
  - oGNTx = 1 and oREADYx = 1; the other requester sees oGNT/oREADY = 0.
  - A beat is the condition iVALIDx && oREADYx in a cycle.
  - On a beat, the next cycle shows oWE = 1, oWADDR = current address and oWDATA = iDATAx (registered, 1-cycle latency).
  - After each beat: address increments modulo DEPTH (31 wraps to 0) and the remaining count decrements.
  - When the final beat is accepted, go to DONE. oREADYx drops in the cycle after that beat.
  - iVALIDx low: no write occurs and the arbiter keeps waiting; there is no timeout.
- DONE (1 cycle):
  - oDONEx = 1 and oGNTx still = 1.
  - The round-robin pointer moves to the other requester.
  - Go to IDLE.
- Abort: if iREQx falls while in LOAD or XFER, go to IDLE next cycle.
  - Beats already accepted are still written.
  - No oDONEx pulse.
  - The round-robin pointer still moves to the other requester.
- Minimum spacing: at least one IDLE cycle separates consecutive bursts. Throughput is one character per cycle while iVALID is held.
- Request changes: iBASE and iLEN changes after LOAD are ignored.
- Reset mid-burst: the next edge with iRST_N = 0 clears all outputs. A pending oWE is dropped.

Test Plan:
- Single burst: iREQ0 with base 3, len 4, iVALID0 held high -> oWE on 4 consecutive cycles at addresses 3, 4, 5, 6 carrying the supplied data, then one oDONE0 pulse, oGNT0 deasserted, oGNT1 never high.
- Wrap and saturate: base 30, len 3 -> writes to addresses 30, 31, 0. Separately, len 40 -> exactly 32 writes, with the last address equal to base − 1 mod 32.
- Tie and round-robin: iREQ0 and iREQ1 both held high from reset, each with len 2 -> order 0, 1, 0, 1. There are never two oGNT high at once and never oREADY to a non-granted requester.
- Stalls: len 3, with iVALID0 toggling 1, 0, 0, 1, 0, 1 -> exactly 3 writes with correct addresses, no write in gap cycles, then oDONE0.
- Zero length and abort: len 0 -> LOAD, then DONE with no oWE. Separately, iREQ1 dropped after 2 of 5 beats -> 2 writes, no oDONE1, and a waiting requester 0 is granted next.
- Reset mid-burst: iRST_N low during XFER -> all outputs 0 on the next edge. A fresh request after release is served from IDLE with requester 0 favoured.
